// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared constants for the direct-mapped instruction cache
package icache_pkg;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_SETS       = 64;
    localparam int WORD_LSB       = 2;

    typedef logic [31:0] word_t;

    function automatic int tag_lsb(input int line_words, input int sets);
        return WORD_LSB + $clog2(line_words) + $clog2(sets);
    endfunction
endpackage

// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetch-side request port and line refill channel
interface icache_if;
    import icache_pkg::*;

    logic       inst_sram_en;
    logic [3:0] inst_sram_wen;
    word_t      inst_sram_addr;
    word_t      inst_sram_wdata;
    word_t      inst_sram_rdata;
    logic       stallreq;
    logic       inv;
    logic       mem_rd_req;
    word_t      mem_rd_addr;
    logic       mem_rd_valid;
    word_t      mem_rd_data;

    modport master (
        output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata, inv,
               mem_rd_valid, mem_rd_data,
        input  inst_sram_rdata, stallreq, mem_rd_req, mem_rd_addr
    );

    modport slave (
        input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata, inv,
               mem_rd_valid, mem_rd_data,
        output inst_sram_rdata, stallreq, mem_rd_req, mem_rd_addr
    );
endinterface

// File: rtl/icache_array.sv
// rtl/icache_array.sv - valid/tag/data flop storage with combinational read
module icache_array #(
    parameter  int LINE_WORDS = 4,
    parameter  int SETS       = 64,
    parameter  int TAG_W      = 22,
    localparam int OFF_W      = $clog2(LINE_WORDS),
    localparam int IDX_W      = $clog2(SETS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inv_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [OFF_W-1:0]  rd_word_i,
    output logic              rd_valid_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [31:0]       rd_data_o,
    input  logic              wr_word_en_i,
    input  logic [OFF_W-1:0]  wr_word_i,
    input  logic [31:0]       wr_data_i,
    input  logic              line_we_i,
    input  logic [TAG_W-1:0]  line_tag_i
);
    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS][LINE_WORDS];

    // Invalidate beats a same-cycle line completion so a flushed line never revives.
    always_ff @(posedge clk) begin
        if (rst || inv_i) begin
            valid_q <= '0;
        end else if (line_we_i) begin
            valid_q[idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we_i) begin
            tag_q[idx_i] <= line_tag_i;
        end
        if (wr_word_en_i) begin
            data_q[idx_i][wr_word_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[idx_i];
    assign rd_tag_o   = tag_q[idx_i];
    assign rd_data_o  = data_q[idx_i][rd_word_i];
endmodule

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache with line refill FSM
module icache
    import icache_pkg::*;
#(
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int SETS       = DEF_SETS
) (
    input logic     clk,
    input logic     rst,
    icache_if.slave bus
);
    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int IDX_W   = $clog2(SETS);
    localparam int IDX_LSB = WORD_LSB + OFF_W;
    localparam int TAG_LSB = tag_lsb(LINE_WORDS, SETS);
    localparam int TAG_W   = 32 - TAG_LSB;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REFILL} state_t;

    state_t           state_q, state_d;
    logic             req_v_q;
    word_t            req_addr_q;
    logic [OFF_W-1:0] beat_q, beat_d;
    logic             inv_pend_q, inv_pend_d;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    word_t            rd_data;
    logic             hit, last_beat;
    logic             stall, mem_req, word_we, line_we;
    word_t            rdata, mem_addr;

    logic [IDX_W-1:0] req_idx;
    logic [OFF_W-1:0] req_word;
    logic [TAG_W-1:0] req_tag;
    logic             unused_bits;

    assign req_idx     = req_addr_q[IDX_LSB +: IDX_W];
    assign req_word    = req_addr_q[WORD_LSB +: OFF_W];
    assign req_tag     = req_addr_q[31:TAG_LSB];
    assign unused_bits = ^{bus.inst_sram_wen, bus.inst_sram_wdata, req_addr_q[1:0]};

    icache_array #(
        .LINE_WORDS (LINE_WORDS),
        .SETS       (SETS),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk          (clk),
        .rst          (rst),
        .inv_i        (bus.inv),
        .idx_i        (req_idx),
        .rd_word_i    (req_word),
        .rd_valid_o   (rd_valid),
        .rd_tag_o     (rd_tag),
        .rd_data_o    (rd_data),
        .wr_word_en_i (word_we),
        .wr_word_i    (beat_q),
        .wr_data_i    (bus.mem_rd_data),
        .line_we_i    (line_we),
        .line_tag_i   (req_tag)
    );

    assign hit       = (state_q == S_LOOKUP) && req_v_q && rd_valid && (rd_tag == req_tag);
    assign last_beat = (state_q == S_REFILL) && bus.mem_rd_valid &&
                       (beat_q == OFF_W'(LINE_WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            req_v_q    <= 1'b0;
            req_addr_q <= '0;
            beat_q     <= '0;
            inv_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            inv_pend_q <= inv_pend_d;
            if (!stall) begin
                req_v_q    <= bus.inst_sram_en;
                req_addr_q <= bus.inst_sram_addr;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        inv_pend_d = inv_pend_q;
        stall      = 1'b0;
        rdata      = '0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        word_we    = 1'b0;
        line_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.inst_sram_en) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (hit) begin
                    rdata   = rd_data;
                    state_d = bus.inst_sram_en ? S_LOOKUP : S_IDLE;
                end else begin
                    stall      = 1'b1;
                    state_d    = S_REFILL;
                    inv_pend_d = 1'b0;
                end
            end
            S_REFILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {req_addr_q[31:IDX_LSB], {IDX_LSB{1'b0}}};
                if (bus.inv) inv_pend_d = 1'b1;
                if (bus.mem_rd_valid) begin
                    word_we = 1'b1;
                    beat_d  = beat_q + OFF_W'(1);
                end
                // A flush seen during the burst leaves the line invalid so the lookup refetches.
                if (last_beat) begin
                    beat_d     = '0;
                    line_we    = !(inv_pend_q || bus.inv);
                    inv_pend_d = 1'b0;
                    state_d    = S_LOOKUP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.inst_sram_rdata = rdata;
    assign bus.stallreq        = stall;
    assign bus.mem_rd_req      = mem_req;
    assign bus.mem_rd_addr     = mem_addr;
endmodule
